// File: rtl/axi4_rd_user_pkg.sv
// Shared defaults, TL user-field bundle and ID width helper for the AXI4 read
// user-field tracker.
package axi4_rd_user_pkg;

    localparam int ID_COUNT_DEF = 4;
    localparam int SIZE_W_DEF   = 4;
    localparam int SOURCE_W_DEF = 5;
    localparam int DATA_W_DEF   = 64;

    typedef struct packed {
        logic [SIZE_W_DEF-1:0]   size;
        logic [SOURCE_W_DEF-1:0] source;
        logic                    extra_id;
    } tl_user_t;

    // A single ID still needs one bit of ARID.
    function automatic int id_w(input int id_count);
        return (id_count > 1) ? $clog2(id_count) : 1;
    endfunction

endpackage

// File: rtl/axi4_user_slot.sv
// Single-entry parking slot: a full bit plus a payload register, filled by an
// enq handshake and emptied by a pop strobe.
module axi4_user_slot #(
    parameter int W = 10
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_enq_valid,
    output logic         o_enq_ready,
    input  logic [W-1:0] i_enq_data,
    input  logic         i_deq_pop,
    output logic         o_full,
    output logic [W-1:0] o_deq_data
);

    logic         r_full;
    logic [W-1:0] r_data;
    logic         w_enq_fire;

    assign o_enq_ready = ~r_full;
    assign w_enq_fire  = i_enq_valid & ~r_full;
    assign o_full      = r_full;
    assign o_deq_data  = r_data;

    // An enq can only land on an empty slot, so it never collides with a
    // legitimate pop; a pop of an empty slot is a no-op.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_full <= 1'b0;
        end else if (w_enq_fire) begin
            r_full <= 1'b1;
        end else if (i_deq_pop) begin
            r_full <= 1'b0;
        end
    end

    // Payload is deliberately not reset; stale contents stay visible.
    always_ff @(posedge i_clock) begin
        if (w_enq_fire) begin
            r_data <= i_enq_data;
        end
    end

endmodule

// File: rtl/axi4_rd_user_tracker.sv
// Parks TL size/source/extra_id per ARID on AR issue and re-attaches them to
// the R beats of that ID; one outstanding read per ID.
module axi4_rd_user_tracker
    import axi4_rd_user_pkg::*;
#(
    parameter int ID_COUNT  = ID_COUNT_DEF,
    parameter int SIZE_W    = SIZE_W_DEF,
    parameter int SOURCE_W  = SOURCE_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    localparam int ID_W     = id_w(ID_COUNT)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ar_in_valid,
    output logic                ar_in_ready,
    input  logic [ID_W-1:0]     ar_in_id,
    input  logic [SIZE_W-1:0]   ar_in_size,
    input  logic [SOURCE_W-1:0] ar_in_source,
    input  logic                ar_in_extra_id,
    output logic                ar_out_valid,
    input  logic                ar_out_ready,
    output logic [ID_W-1:0]     ar_out_id,
    input  logic                r_in_valid,
    output logic                r_in_ready,
    input  logic [ID_W-1:0]     r_in_id,
    input  logic [DATA_W-1:0]   r_in_data,
    input  logic [1:0]          r_in_resp,
    input  logic                r_in_last,
    output logic                r_out_valid,
    input  logic                r_out_ready,
    output logic [DATA_W-1:0]   r_out_data,
    output logic [1:0]          r_out_resp,
    output logic                r_out_last,
    output logic [SIZE_W-1:0]   r_out_size,
    output logic [SOURCE_W-1:0] r_out_source,
    output logic                r_out_extra_id,
    output logic                err_unexpected_r
);

    localparam int USER_W = SIZE_W + SOURCE_W + 1;
    localparam int SLOTS  = 1 << ID_W;

    logic [SLOTS-1:0]  w_full;
    logic [SLOTS-1:0]  w_enq_ready;
    logic [USER_W-1:0] w_slot_data [SLOTS];
    logic [USER_W-1:0] w_enq_data;
    logic [USER_W-1:0] w_rd_data;
    logic              w_ar_open;
    logic              w_r_fire;
    logic              r_err;

    // AR side only looks at the slot selected by ar_in_id.
    assign w_ar_open    = w_enq_ready[ar_in_id];
    assign ar_out_valid = ar_in_valid & w_ar_open;
    assign ar_in_ready  = ar_out_ready & w_ar_open;
    assign ar_out_id    = ar_in_id;
    assign w_enq_data   = {ar_in_size, ar_in_source, ar_in_extra_id};

    assign w_r_fire     = r_in_valid & r_out_ready;

    generate
        for (genvar i = 0; i < SLOTS; i++) begin : g_slot
            if (i < ID_COUNT) begin : g_real
                logic w_enq_valid;
                logic w_pop;

                assign w_enq_valid = ar_in_valid & ar_out_ready & (ar_in_id == ID_W'(i));
                assign w_pop       = w_r_fire & r_in_last & (r_in_id == ID_W'(i));

                axi4_user_slot #(
                    .W(USER_W)
                ) u_slot (
                    .i_clock     (clock),
                    .i_reset     (reset),
                    .i_enq_valid (w_enq_valid),
                    .o_enq_ready (w_enq_ready[i]),
                    .i_enq_data  (w_enq_data),
                    .i_deq_pop   (w_pop),
                    .o_full      (w_full[i]),
                    .o_deq_data  (w_slot_data[i])
                );
            end else begin : g_pad
                // IDs beyond ID_COUNT never accept an AR and read as empty.
                assign w_enq_ready[i] = 1'b0;
                assign w_full[i]      = 1'b0;
                assign w_slot_data[i] = '0;
            end
        end
    endgenerate

    assign r_out_valid = r_in_valid;
    assign r_in_ready  = r_out_ready;
    assign r_out_data  = r_in_data;
    assign r_out_resp  = r_in_resp;
    assign r_out_last  = r_in_last;
    assign w_rd_data   = w_slot_data[r_in_id];
    assign {r_out_size, r_out_source, r_out_extra_id} = w_rd_data;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (w_r_fire && !w_full[r_in_id]) begin
            r_err <= 1'b1;
        end
    end

    assign err_unexpected_r = r_err;

endmodule

// File: tb/tb_axi4_rd_user_tracker.sv
// Directed bench for axi4_rd_user_tracker: expected AR ids and R beats are
// queued at stimulus time and checked by free-running monitors.
module tb_axi4_rd_user_tracker;
    import axi4_rd_user_pkg::*;

    localparam int ID_W = id_w(ID_COUNT_DEF);
    localparam int RW   = DATA_W_DEF + 2 + 1 + SIZE_W_DEF + SOURCE_W_DEF + 1;

    logic                    clock;
    logic                    reset;
    logic                    ar_in_valid;
    logic                    ar_in_ready;
    logic [ID_W-1:0]         ar_in_id;
    logic [SIZE_W_DEF-1:0]   ar_in_size;
    logic [SOURCE_W_DEF-1:0] ar_in_source;
    logic                    ar_in_extra_id;
    logic                    ar_out_valid;
    logic                    ar_out_ready;
    logic [ID_W-1:0]         ar_out_id;
    logic                    r_in_valid;
    logic                    r_in_ready;
    logic [ID_W-1:0]         r_in_id;
    logic [DATA_W_DEF-1:0]   r_in_data;
    logic [1:0]              r_in_resp;
    logic                    r_in_last;
    logic                    r_out_valid;
    logic                    r_out_ready;
    logic [DATA_W_DEF-1:0]   r_out_data;
    logic [1:0]              r_out_resp;
    logic                    r_out_last;
    logic [SIZE_W_DEF-1:0]   r_out_size;
    logic [SOURCE_W_DEF-1:0] r_out_source;
    logic                    r_out_extra_id;
    logic                    err_unexpected_r;

    logic [RW-1:0]   exp_q[$];
    logic [ID_W-1:0] ar_exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    axi4_rd_user_tracker dut (
        .clock            (clock),
        .reset            (reset),
        .ar_in_valid      (ar_in_valid),
        .ar_in_ready      (ar_in_ready),
        .ar_in_id         (ar_in_id),
        .ar_in_size       (ar_in_size),
        .ar_in_source     (ar_in_source),
        .ar_in_extra_id   (ar_in_extra_id),
        .ar_out_valid     (ar_out_valid),
        .ar_out_ready     (ar_out_ready),
        .ar_out_id        (ar_out_id),
        .r_in_valid       (r_in_valid),
        .r_in_ready       (r_in_ready),
        .r_in_id          (r_in_id),
        .r_in_data        (r_in_data),
        .r_in_resp        (r_in_resp),
        .r_in_last        (r_in_last),
        .r_out_valid      (r_out_valid),
        .r_out_ready      (r_out_ready),
        .r_out_data       (r_out_data),
        .r_out_resp       (r_out_resp),
        .r_out_last       (r_out_last),
        .r_out_size       (r_out_size),
        .r_out_source     (r_out_source),
        .r_out_extra_id   (r_out_extra_id),
        .err_unexpected_r (err_unexpected_r)
    );

    // Clock and watchdog
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitors
    always @(negedge clock) begin
        if (reset && r_out_valid && r_out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL r_beat_unexpected: got data=%0h with no expected beat queued", r_out_data);
            end else begin
                logic [RW-1:0] exp_v;
                logic [RW-1:0] act_v;
                exp_v = exp_q.pop_front();
                act_v = {r_out_data, r_out_resp, r_out_last, r_out_size, r_out_source, r_out_extra_id};
                if (act_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL r_beat: got %0h expected %0h", act_v, exp_v);
                end
            end
        end
    end

    always @(negedge clock) begin
        if (reset && ar_out_valid && ar_out_ready) begin
            n_checks++;
            if (ar_exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL ar_unexpected: got id=%0d with no expected AR queued", ar_out_id);
            end else begin
                logic [ID_W-1:0] exp_id;
                exp_id = ar_exp_q.pop_front();
                if (ar_out_id !== exp_id) begin
                    n_fail++;
                    $display("FAIL ar_id: got %0d expected %0d", ar_out_id, exp_id);
                end
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic ar_issue(input logic [ID_W-1:0] id, input logic [SIZE_W_DEF-1:0] sz,
                            input logic [SOURCE_W_DEF-1:0] src, input logic ext);
        bit done;
        done           = 1'b0;
        ar_in_valid    = 1'b1;
        ar_in_id       = id;
        ar_in_size     = sz;
        ar_in_source   = src;
        ar_in_extra_id = ext;
        ar_exp_q.push_back(id);
        for (int k = 0; k < 20 && !done; k++) begin
            #1;
            done = ar_in_ready;
            tick();
        end
        ar_in_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL ar_issue_timeout: id=%0d never accepted", id);
        end
    endtask

    task automatic r_beat(input logic [ID_W-1:0] id, input logic [63:0] data, input logic [1:0] resp,
                          input logic last, input logic [SIZE_W_DEF-1:0] sz,
                          input logic [SOURCE_W_DEF-1:0] src, input logic ext, input bit stall);
        tl_user_t u;
        u.size     = sz;
        u.source   = src;
        u.extra_id = ext;
        r_in_valid = 1'b1;
        r_in_id    = id;
        r_in_data  = data;
        r_in_resp  = resp;
        r_in_last  = last;
        exp_q.push_back({data, resp, last, u});
        if (stall) begin
            r_out_ready = 1'b0;
            #1;
            check("r_stall_out_valid", 64'(r_out_valid), 64'd1);
            check("r_stall_in_ready", 64'(r_in_ready), 64'd0);
            tick();
            r_out_ready = 1'b1;
        end
        tick();
        r_in_valid = 1'b0;
        r_in_last  = 1'b0;
    endtask

    task automatic probe_ready(input string name, input logic [ID_W-1:0] id, input logic exp);
        ar_in_id = id;
        #1;
        check(name, 64'(ar_in_ready), 64'(exp));
    endtask

    // Stimulus
    initial begin
        reset          = 1'b0;
        ar_in_valid    = 1'b0;
        ar_in_id       = '0;
        ar_in_size     = '0;
        ar_in_source   = '0;
        ar_in_extra_id = 1'b0;
        ar_out_ready   = 1'b1;
        r_in_valid     = 1'b0;
        r_in_id        = '0;
        r_in_data      = '0;
        r_in_resp      = '0;
        r_in_last      = 1'b0;
        r_out_ready    = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // Idle after reset
        #1;
        check("idle_ar_in_ready", 64'(ar_in_ready), 64'd1);
        check("idle_ar_out_valid", 64'(ar_out_valid), 64'd0);
        check("idle_err", 64'(err_unexpected_r), 64'd0);
        tick();

        // Single-beat round trip on id 2
        ar_issue(2'd2, 4'd6, 5'h13, 1'b1);
        probe_ready("slot2_full", 2'd2, 1'b0);
        tick();
        tick();
        r_beat(2'd2, 64'hDEAD_BEEF_0000_0002, 2'b00, 1'b1, 4'd6, 5'h13, 1'b1, 1'b0);
        probe_ready("slot2_free", 2'd2, 1'b1);
        ar_issue(2'd2, 4'd1, 5'h02, 1'b0);
        r_beat(2'd2, 64'h0000_0000_0000_0022, 2'b10, 1'b1, 4'd1, 5'h02, 1'b0, 1'b0);

        // Second AR to a busy id is held until the first read completes
        ar_issue(2'd1, 4'd2, 5'h0A, 1'b0);
        ar_in_valid    = 1'b1;
        ar_in_id       = 2'd1;
        ar_in_size     = 4'd3;
        ar_in_source   = 5'h0B;
        ar_in_extra_id = 1'b1;
        ar_exp_q.push_back(2'd1);
        #1;
        check("ar_block_ready", 64'(ar_in_ready), 64'd0);
        check("ar_block_valid", 64'(ar_out_valid), 64'd0);
        tick();
        r_in_valid = 1'b1;
        r_in_id    = 2'd1;
        r_in_data  = 64'h1111_0000_AAAA_0001;
        r_in_resp  = 2'b00;
        r_in_last  = 1'b1;
        exp_q.push_back({64'h1111_0000_AAAA_0001, 2'b00, 1'b1, 4'd2, 5'h0A, 1'b0});
        #1;
        check("ar_block_at_r_fire", 64'(ar_in_ready), 64'd0);
        tick();
        r_in_valid = 1'b0;
        r_in_last  = 1'b0;
        #1;
        check("ar_retry_ready", 64'(ar_in_ready), 64'd1);
        check("ar_retry_valid", 64'(ar_out_valid), 64'd1);
        tick();
        ar_in_valid = 1'b0;
        r_beat(2'd1, 64'h1111_0000_BBBB_0002, 2'b01, 1'b1, 4'd3, 5'h0B, 1'b1, 1'b0);

        // Four-beat burst on id 0 with a downstream stall
        ar_issue(2'd0, 4'd3, 5'h05, 1'b0);
        r_beat(2'd0, 64'h0123_4567_89AB_CDE0, 2'b00, 1'b0, 4'd3, 5'h05, 1'b0, 1'b0);
        r_beat(2'd0, 64'h0123_4567_89AB_CDE1, 2'b01, 1'b0, 4'd3, 5'h05, 1'b0, 1'b1);
        r_beat(2'd0, 64'h0123_4567_89AB_CDE2, 2'b00, 1'b0, 4'd3, 5'h05, 1'b0, 1'b0);
        probe_ready("slot0_held_in_burst", 2'd0, 1'b0);
        r_beat(2'd0, 64'h0123_4567_89AB_CDE3, 2'b11, 1'b1, 4'd3, 5'h05, 1'b0, 1'b0);
        probe_ready("slot0_free_after_last", 2'd0, 1'b1);

        // Unexpected R on an empty slot shows the stale payload and sets the flag
        ar_issue(2'd3, 4'd4, 5'h1F, 1'b1);
        r_beat(2'd3, 64'h3333_3333_3333_3333, 2'b00, 1'b1, 4'd4, 5'h1F, 1'b1, 1'b0);
        #1;
        check("err_after_legal", 64'(err_unexpected_r), 64'd0);
        r_beat(2'd3, 64'h3333_3333_DEAD_0003, 2'b10, 1'b1, 4'd4, 5'h1F, 1'b1, 1'b0);
        #1;
        check("err_set", 64'(err_unexpected_r), 64'd1);
        probe_ready("slot3_stays_empty", 2'd3, 1'b1);

        // Same-cycle AR fire on id 0 and last-R fire on id 1
        ar_issue(2'd1, 4'd5, 5'h11, 1'b1);
        ar_in_valid    = 1'b1;
        ar_in_id       = 2'd0;
        ar_in_size     = 4'd7;
        ar_in_source   = 5'h07;
        ar_in_extra_id = 1'b0;
        ar_exp_q.push_back(2'd0);
        r_in_valid = 1'b1;
        r_in_id    = 2'd1;
        r_in_data  = 64'h5555_AAAA_5555_AAAA;
        r_in_resp  = 2'b00;
        r_in_last  = 1'b1;
        exp_q.push_back({64'h5555_AAAA_5555_AAAA, 2'b00, 1'b1, 4'd5, 5'h11, 1'b1});
        #1;
        check("same_cycle_ar_ready", 64'(ar_in_ready), 64'd1);
        tick();
        ar_in_valid = 1'b0;
        r_in_valid  = 1'b0;
        r_in_last   = 1'b0;
        probe_ready("same_cycle_slot0_full", 2'd0, 1'b0);
        probe_ready("same_cycle_slot1_empty", 2'd1, 1'b1);
        r_beat(2'd0, 64'h7777_0000_0000_0007, 2'b01, 1'b1, 4'd7, 5'h07, 1'b0, 1'b0);
        #1;
        check("err_sticky", 64'(err_unexpected_r), 64'd1);

        // Reset in the middle of a burst
        ar_issue(2'd2, 4'd2, 5'h03, 1'b0);
        r_beat(2'd2, 64'h2222_0000_0000_0001, 2'b00, 1'b0, 4'd2, 5'h03, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        check("err_cleared_by_reset", 64'(err_unexpected_r), 64'd0);
        probe_ready("slot2_cleared_by_reset", 2'd2, 1'b1);
        r_beat(2'd2, 64'h2222_0000_0000_0002, 2'b00, 1'b1, 4'd2, 5'h03, 1'b0, 1'b0);
        #1;
        check("err_after_reset_burst", 64'(err_unexpected_r), 64'd1);

        // Drain and report
        for (int k = 0; k < 20 && (exp_q.size() != 0 || ar_exp_q.size() != 0); k++) tick();
        check("r_queue_drained", 64'(exp_q.size()), 64'd0);
        check("ar_queue_drained", 64'(ar_exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
